// File: rtl/pwl_pkg.sv
// Shared fixed-point constants for the piecewise-linear evaluator and its
// segment selector: default operand width, fraction bits and the signed
// saturation bounds of the result format.
package pwl_pkg;

    localparam int unsigned PWL_W    = 32;
    localparam int unsigned PWL_FRAC = 27;

    // Largest / smallest signed value representable in w bits (w <= 63).
    function automatic longint pwl_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint pwl_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint PWL_Y_MAX = pwl_max(PWL_W);
    localparam longint PWL_Y_MIN = pwl_min(PWL_W);

endpackage

// File: rtl/pwl_sat_round.sv
// Combinational back end of the evaluator: rounds the full product to the
// result format (round half up), adds the intercept and clips to the signed
// W-bit range.
//   p     : full 2W-bit signed product m*x
//   c     : signed intercept
//   y_c   : rounded, clipped result
//   sat_c : high when clipping occurred
module pwl_sat_round
    import pwl_pkg::*;
#(
    parameter int unsigned W    = PWL_W,
    parameter int unsigned FRAC = PWL_FRAC
) (
    input  logic signed [2*W-1:0] p,
    input  logic signed [W-1:0]   c,
    output logic signed [W-1:0]   y_c,
    output logic                  sat_c
);

    // Two guard bits above the product keep the rounding add and the
    // intercept add free of overflow before the clip decision.
    localparam int unsigned RW = 2*W + 2;

    localparam logic signed [RW-1:0] YMAX = RW'(pwl_max(W));
    localparam logic signed [RW-1:0] YMIN = RW'(pwl_min(W));
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC - 1);

    logic signed [RW-1:0] p_ext;
    logic signed [RW-1:0] c_ext;
    logic signed [RW-1:0] q;
    logic signed [RW-1:0] r;

    // Round, shift, add, clip.
    always_comb begin
        p_ext = RW'(p);
        c_ext = RW'(c);
        q     = (p_ext + HALF) >>> FRAC;
        r     = q + c_ext;
        y_c   = r[W-1:0];
        sat_c = 1'b0;
        if (r > YMAX) begin
            y_c   = YMAX[W-1:0];
            sat_c = 1'b1;
        end else if (r < YMIN) begin
            y_c   = YMIN[W-1:0];
            sat_c = 1'b1;
        end
    end

endmodule

// File: rtl/pwl_eval.sv
// Three-stage fixed-point evaluator y = m*x + c for one selected segment.
// S1 registers the operand triple, S2 the full product, S3 the rounded and
// clipped result. A single global advance stalls the whole pipe.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (data = x, m, c)
//   out_valid / out_ready : result handshake (y, sat)
//   sat_count             : saturated results delivered, sticks at 0xFFFF
module pwl_eval
    import pwl_pkg::*;
#(
    parameter int unsigned W    = PWL_W,
    parameter int unsigned FRAC = PWL_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] data,
    input  logic signed [W-1:0] m,
    input  logic signed [W-1:0] c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] y,
    output logic                sat,
    output logic [15:0]         sat_count
);

    localparam int unsigned PW = 2*W;

    logic                 advance;
    logic                 v1;
    logic                 v2;
    logic                 v3;
    logic signed [W-1:0]  x1;
    logic signed [W-1:0]  m1;
    logic signed [W-1:0]  c1;
    logic signed [PW-1:0] p2;
    logic signed [W-1:0]  c2;
    logic signed [PW-1:0] prod;
    logic signed [W-1:0]  y_nxt;
    logic                 sat_nxt;

    // The pipe moves only when the output slot is empty or being drained.
    assign advance   = !v3 || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3;

    assign prod = PW'(x1) * PW'(m1);

    pwl_sat_round #(
        .W    (W),
        .FRAC (FRAC)
    ) u_sat_round (
        .p     (p2),
        .c     (c2),
        .y_c   (y_nxt),
        .sat_c (sat_nxt)
    );

    // Pipeline stages and valid bits; data of invalid stages is don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            y   <= '0;
            sat <= 1'b0;
        end else if (advance) begin
            v1  <= in_valid;
            x1  <= data;
            m1  <= m;
            c1  <= c;
            v2  <= v1;
            p2  <= prod;
            c2  <= c1;
            v3  <= v2;
            y   <= y_nxt;
            sat <= sat_nxt;
        end
    end

    // Count saturated results as they are handed off.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (v3 && out_ready && sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pwl_eval.sv
module tb_pwl_eval;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data;
    logic [31:0] m;
    logic [31:0] c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        sat;
    logic [15:0] sat_count;

    pwl_eval #(.W(32), .FRAC(27)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .m         (m),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat),
        .sat_count (sat_count)
    );

    typedef struct packed {
        logic [31:0] y;
        logic        sat;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [31:0] drv_ey = 32'd0;
    logic        drv_es = 1'b0;
    bit          rnd_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: round half up of m*x at 27 fraction bits, plus c, clipped.
    function automatic void model(input logic [31:0] x, input logic [31:0] mm,
                                  input logic [31:0] cc,
                                  output logic [31:0] ey, output logic es);
        longint p;
        longint r;
        p = longint'($signed(x)) * longint'($signed(mm));
        r = ((p + 64'sd67108864) >>> 27) + longint'($signed(cc));
        if (r > 64'sh7FFF_FFFF) begin
            ey = 32'h7FFF_FFFF; es = 1'b1;
        end else if (r < -64'sh8000_0000) begin
            ey = 32'h8000_0000; es = 1'b1;
        end else begin
            ey = 32'(r); es = 1'b0;
        end
    endfunction

    // Input side: expected result is queued when a triple is accepted.
    always @(negedge clk) begin
        if (rst) begin
            n_acc -= q.size();
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back('{y: drv_ey, sat: drv_es});
            n_acc++;
        end
    end

    // Output side: compare presented result against queue head.
    always @(negedge clk) begin
        if (rst) begin
            exp_cnt = 16'd0;
        end else begin
            chk("sat_count", 64'(sat_count), 64'(exp_cnt));
            if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got y=%h with nothing expected (t=%0t)", y, $time);
                end else begin
                    chk("y", 64'(y), 64'(q[0].y));
                    chk("sat", 64'(sat), 64'(q[0].sat));
                    if (out_ready) begin
                        if (q[0].sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] mm, input logic [31:0] cc,
                        input logic [31:0] ey, input logic es);
        bit acc;
        data = x; m = mm; c = cc; drv_ey = ey; drv_es = es;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no acceptance expected acceptance x=%h", x);
        end
    endtask

    task automatic send_model(input logic [31:0] x, input logic [31:0] mm, input logic [31:0] cc);
        logic [31:0] ey;
        logic        es;
        model(x, mm, cc, ey, es);
        send(x, mm, cc, ey, es);
    endtask

    // Empty pipe required: out_valid must rise exactly after the third edge.
    task automatic lat_test(input logic [31:0] x, input logic [31:0] mm, input logic [31:0] cc,
                            input logic [31:0] ey, input logic es);
        send(x, mm, cc, ey, es);
        @(negedge clk); chk("lat_edge0_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_edge1_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_edge2_valid", 64'(out_valid), 64'd1);
        chk("lat_y", 64'(y), 64'(ey));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        data = '0; m = '0; c = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // 1.0 * 0.5 + 0.25
        lat_test(32'h0800_0000, 32'h0400_0000, 32'h0200_0000, 32'h0600_0000, 1'b0);

        send(32'hF800_0000, 32'h0400_0000, 32'h0000_0000, 32'hFC00_0000, 1'b0);
        send(32'h0400_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        send(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1);
        idle(6);
        chk("sat_count_two", 64'(sat_count), 64'd2);

        // Backpressure: six triples while the consumer stalls.
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    send(32'h0800_0000, 32'(k) << 24, 32'(k), (32'(k) << 24) + 32'(k), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(10);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Reset with three results in flight, plus a triple offered during reset.
        out_ready = 1'b0;
        send_model(32'h0100_0000, 32'h0800_0000, 32'h0000_0011);
        send_model(32'h0200_0000, 32'h0800_0000, 32'h0000_0022);
        send_model(32'h0300_0000, 32'h0800_0000, 32'h0000_0033);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        data = 32'h0800_0000; m = 32'h0800_0000; c = 32'h0000_0044;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_sat_count", 64'(sat_count), 64'd0);
        @(posedge clk); #1;
        idle(5);
        // -1.0 * -1.0 + 0
        lat_test(32'hF800_0000, 32'hF800_0000, 32'h0000_0000, 32'h0800_0000, 1'b0);

        // Random stream with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send_model($urandom, 32'($signed($urandom) >>> $urandom_range(0, 8)),
                               32'($signed($urandom) >>> $urandom_range(0, 4)));
                    idle($urandom_range(0, 2));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) idle(1);
        idle(2);
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        chk("final_out_count", 64'(n_out), 64'(n_acc));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
